// File: rtl/binary_div_17_9_seq.sv
// Sequential signed 17-bit by 9-bit divider: restoring shift-subtract on magnitudes,
// sign fix-up in a final cycle. Truncating quotient, remainder takes the dividend's sign.
module binary_div_17_9_seq (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic signed [16:0] dividend,
    input  logic signed [8:0]  divisor,
    output logic signed [8:0]  Q,
    output logic signed [8:0]  R,
    output logic               busy,
    output logic               done,
    output logic               div_by_zero,
    output logic               overflow
);

    typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

    state_e      state_q, state_d;
    logic [4:0]  cnt_q;
    logic [16:0] quo_q;
    logic [9:0]  rem_q;
    logic [8:0]  dvsr_q;
    logic        q_neg_q;
    logic        r_neg_q;
    logic        zero_q;

    logic [16:0] dvd_u, dvd_mag;
    logic [8:0]  dvs_u, dvs_mag;
    logic [9:0]  rem_sh, rem_nx;
    logic        ge;
    logic [16:0] quo_nx;
    logic [8:0]  q_fix, r_fix;
    logic        ovf_fix;

    // Magnitudes are computed unsigned so -65536 and -256 land on 17'h10000 / 9'h100.
    always_comb begin
        dvd_u   = dividend;
        dvs_u   = divisor;
        dvd_mag = dividend[16] ? (~dvd_u + 17'd1) : dvd_u;
        dvs_mag = divisor[8] ? (~dvs_u + 9'd1) : dvs_u;
    end

    always_comb begin
        rem_sh = 10'({rem_q, quo_q[16]});
        ge     = rem_sh >= {1'b0, dvsr_q};
        rem_nx = ge ? (rem_sh - {1'b0, dvsr_q}) : rem_sh;
        quo_nx = {quo_q[15:0], ge};
    end

    always_comb begin
        q_fix   = q_neg_q ? (~quo_q[8:0] + 9'd1) : quo_q[8:0];
        r_fix   = r_neg_q ? (~rem_q[8:0] + 9'd1) : rem_q[8:0];
        ovf_fix = q_neg_q ? (quo_q > 17'd256) : (quo_q > 17'd255);
    end

    always_comb begin
        state_d = state_q;
        busy    = (state_q != StIdle);
        case (state_q)
            StIdle: if (start) state_d = (divisor == 9'sd0) ? StFix : StCalc;
            StCalc: if (cnt_q == 5'd0) state_d = StFix;
            StFix:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= 5'd0;
            quo_q       <= 17'd0;
            rem_q       <= 10'd0;
            dvsr_q      <= 9'd0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            zero_q      <= 1'b0;
            Q           <= 9'sd0;
            R           <= 9'sd0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            state_q <= state_d;
            done    <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        cnt_q   <= 5'd16;
                        quo_q   <= dvd_mag;
                        rem_q   <= 10'd0;
                        dvsr_q  <= dvs_mag;
                        q_neg_q <= dividend[16] ^ divisor[8];
                        r_neg_q <= dividend[16];
                        zero_q  <= (divisor == 9'sd0);
                    end
                end
                StCalc: begin
                    quo_q <= quo_nx;
                    rem_q <= rem_nx;
                    cnt_q <= (cnt_q == 5'd0) ? 5'd0 : cnt_q - 5'd1;
                end
                StFix: begin
                    done <= 1'b1;
                    if (zero_q) begin
                        Q           <= 9'sd0;
                        R           <= 9'sd0;
                        div_by_zero <= 1'b1;
                        overflow    <= 1'b0;
                    end else begin
                        Q           <= q_fix;
                        R           <= r_fix;
                        div_by_zero <= 1'b0;
                        overflow    <= ovf_fix;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_binary_div_17_9_seq.sv
// Bench for binary_div_17_9_seq: directed cases plus a random sweep against integer arithmetic.
module tb_binary_div_17_9_seq;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic signed [16:0] dividend;
    logic signed [8:0]  divisor;
    logic signed [8:0]  Q, R;
    logic               busy, done, div_by_zero, overflow;

    int total = 0;
    int bad   = 0;

    binary_div_17_9_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .Q           (Q),
        .R           (R),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic signed [16:0] a, input logic signed [8:0] b);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    // j counts cycles after the start edge; -1 means done never came.
    task automatic wait_done(output int lat, output int bc);
        lat = -1;
        bc  = 0;
        for (int j = 0; j < 40; j++) begin
            if (done) begin
                lat = j;
                break;
            end
            if (busy) bc++;
            tick();
        end
    endtask

    task automatic check_res(input string tag, input logic signed [16:0] a,
                             input logic signed [8:0] b);
        int ai, bi, q, r;
        logic [8:0] eq, er;
        logic ez, eo;
        ai = int'(a);
        bi = int'(b);
        if (bi == 0) begin
            eq = 9'd0; er = 9'd0; ez = 1'b1; eo = 1'b0;
        end else begin
            q  = ai / bi;
            r  = ai % bi;
            eq = q[8:0];
            er = r[8:0];
            ez = 1'b0;
            eo = (q < -256) || (q > 255);
        end
        chk({tag, ".Q"}, {23'd0, $unsigned(Q)}, {23'd0, eq});
        chk({tag, ".R"}, {23'd0, $unsigned(R)}, {23'd0, er});
        chk({tag, ".dbz"}, {31'd0, div_by_zero}, {31'd0, ez});
        chk({tag, ".ovf"}, {31'd0, overflow}, {31'd0, eo});
    endtask

    task automatic run_op(input string tag, input logic signed [16:0] a,
                          input logic signed [8:0] b);
        int lat, bc, el;
        start_op(a, b);
        wait_done(lat, bc);
        el = (b == 9'sd0) ? 1 : 18;
        chk({tag, ".lat"}, lat, el);
        chk({tag, ".busy"}, bc, el);
        check_res(tag, a, b);
    endtask

    initial begin
        int lat, bc, cnt;
        logic signed [16:0] ra;
        logic signed [8:0]  rb;
        int sel;

        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = 17'sd0;
        divisor  = 9'sd0;
        #12;
        chk("rst.Q", {23'd0, $unsigned(Q)}, 0);
        chk("rst.R", {23'd0, $unsigned(R)}, 0);
        chk("rst.done", {31'd0, done}, 0);
        chk("rst.busy", {31'd0, busy}, 0);
        chk("rst.dbz", {31'd0, div_by_zero}, 0);
        chk("rst.ovf", {31'd0, overflow}, 0);
        rst_n = 1'b1;
        tick();

        run_op("p1000_7", 17'sd1000, 9'sd7);
        chk("p1000_7.Qk", {23'd0, $unsigned(Q)}, 142);
        chk("p1000_7.Rk", {23'd0, $unsigned(R)}, 6);
        run_op("n1000_7", -17'sd1000, 9'sd7);
        chk("n1000_7.Qk", {23'd0, $unsigned(Q)}, 32'h172);
        chk("n1000_7.Rk", {23'd0, $unsigned(R)}, 32'h1FA);
        run_op("p1000_n7", 17'sd1000, -9'sd7);
        run_op("n1000_n7", -17'sd1000, -9'sd7);
        run_op("z123", 17'sd123, 9'sd0);
        run_op("clr_dbz", 17'sd1000, 9'sd7);
        run_op("ovf65535_1", 17'sd65535, 9'sd1);
        chk("ovf65535_1.Qk", {23'd0, $unsigned(Q)}, 32'h1FF);
        run_op("ovfm65536_m1", -17'sd65536, -9'sd1);
        run_op("ovfm65536_m256", -17'sd65536, -9'sd256);
        chk("ovfm65536_m256.Qk", {23'd0, $unsigned(Q)}, 32'h100);
        run_op("m256_1", -17'sd256, 9'sd1);
        run_op("p256_1", 17'sd256, 9'sd1);
        run_op("p255_1", 17'sd255, 9'sd1);
        run_op("zero_dvd", 17'sd0, -9'sd5);
        run_op("m65536_255", -17'sd65536, 9'sd255);
        run_op("p65535_m256", 17'sd65535, -9'sd256);

        // start during CALC must not disturb the running operation
        start_op(17'sd1000, 9'sd7);
        repeat (4) tick();
        dividend = -17'sd500;
        divisor  = 9'sd3;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        wait_done(lat, bc);
        chk("ign.lat", lat, 13);
        check_res("ign", 17'sd1000, 9'sd7);

        // reset in the middle of CALC
        start_op(-17'sd30000, 9'sd11);
        repeat (9) tick();
        rst_n = 1'b0;
        #1;
        chk("mrst.Q", {23'd0, $unsigned(Q)}, 0);
        chk("mrst.R", {23'd0, $unsigned(R)}, 0);
        chk("mrst.done", {31'd0, done}, 0);
        chk("mrst.busy", {31'd0, busy}, 0);
        chk("mrst.dbz", {31'd0, div_by_zero}, 0);
        chk("mrst.ovf", {31'd0, overflow}, 0);
        tick();
        rst_n = 1'b1;
        cnt = 0;
        repeat (25) begin
            tick();
            if (done || busy) cnt++;
        end
        chk("mrst.quiet", cnt, 0);
        run_op("post_rst", -17'sd30000, 9'sd11);

        for (int i = 0; i < 3000; i++) begin
            ra  = 17'($urandom);
            sel = $urandom_range(0, 9);
            if (sel == 0) rb = 9'sd0;
            else if (sel < 4) rb = 9'($urandom_range(1, 15)) * (($urandom_range(0, 1) != 0) ? -9'sd1 : 9'sd1);
            else rb = 9'($urandom);
            run_op("rnd", ra, rb);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
